// File: rtl/vpacker_if.sv
// Pixel-stream and memory-write bundle for the 6 bpp framebuffer packer.
// The packer sits on the slave side: it consumes pixels and produces write strobes.
interface vpacker_if #(
   parameter int BPP    = 6,
   parameter int IWIDTH = 2,
   parameter int AWIDTH = 16
);
   logic [BPP-1:0]    PixelIn;
   logic              PixelValid;
   logic              PixelReady;
   logic              FrameStart;
   logic              MemReady;
   logic              ReqWrite;
   logic [7:0]        DataOut;
   logic [IWIDTH-1:0] WriteIndex;
   logic [AWIDTH-1:0] WriteAddr;
   logic              FrameDone;

   modport slave (
      input  PixelIn, PixelValid, FrameStart, MemReady,
      output PixelReady, ReqWrite, DataOut, WriteIndex, WriteAddr, FrameDone
   );

   modport master (
      output PixelIn, PixelValid, FrameStart, MemReady,
      input  PixelReady, ReqWrite, DataOut, WriteIndex, WriteAddr, FrameDone
   );
endinterface

// File: rtl/vpacker.sv
// Pixel packer / video-memory writer: collects four 6-bit pixels, packs them
// into three bytes and emits one byte per MemReady cycle with a linear frame
// address that wraps at FRAME_BYTES. The byte layout matches the scan-out unpacker.
module vpacker #(
   parameter int BPP         = 6,
   parameter int PSIZE       = 4,
   parameter int IWIDTH      = 2,
   parameter int AWIDTH      = 16,
   parameter int FRAME_BYTES = 48000
) (
   input logic     PixelClk,
   input logic     Reset,
   vpacker_if.slave bus
);
   typedef enum logic {COLLECT, EMIT} state_t;

   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(FRAME_BYTES - 1);
   localparam logic [1:0]        LAST_PIX  = 2'(PSIZE - 1);
   localparam logic [IWIDTH-1:0] LAST_BYTE = IWIDTH'(2);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [IWIDTH-1:0] byte_q, byte_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [BPP-1:0]    pix_q [PSIZE];
   logic [BPP-1:0]    pix_d [PSIZE];
   logic              req_q, req_d;
   logic              done_q, done_d;
   logic [7:0]        data_q, data_d;
   logic [IWIDTH-1:0] idx_q, idx_d;
   logic [AWIDTH-1:0] waddr_q, waddr_d;

   logic              pixel_ready;
   logic [7:0]        cur_byte;

   // Ready is combinational so a FrameStart or Reset blocks the accept in the same cycle.
   assign pixel_ready = (state_q == COLLECT) && !bus.FrameStart && !Reset;

   // Select the packed byte for the current emit position; bytes straddle pixel boundaries.
   always_comb begin
      cur_byte = 8'h00;
      case (byte_q)
         IWIDTH'(0): cur_byte = {pix_q[1][1:0], pix_q[0][5:0]};
         IWIDTH'(1): cur_byte = {pix_q[2][3:0], pix_q[1][5:2]};
         default:    cur_byte = {pix_q[3][5:0], pix_q[2][5:4]};
      endcase
   end

   // Next-state logic: collect pixels, then emit three bytes as memory allows.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      addr_d  = addr_q;
      pix_d   = pix_q;
      req_d   = 1'b0;
      done_d  = 1'b0;
      data_d  = data_q;
      idx_d   = idx_q;
      waddr_d = waddr_q;

      if (bus.FrameStart) begin
         // Restart the frame: drop any partial group or half-emitted group.
         state_d = COLLECT;
         cnt_d   = 2'd0;
         byte_d  = '0;
         addr_d  = '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (bus.PixelValid && pixel_ready) begin
                  pix_d[cnt_q] = bus.PixelIn;
                  if (cnt_q == LAST_PIX) begin
                     cnt_d   = 2'd0;
                     byte_d  = '0;
                     state_d = EMIT;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
            end
            EMIT: begin
               if (bus.MemReady) begin
                  req_d   = 1'b1;
                  data_d  = cur_byte;
                  idx_d   = byte_q;
                  waddr_d = addr_q;
                  if (addr_q == LAST_ADDR) begin
                     addr_d = '0;
                     done_d = 1'b1;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
                  if (byte_q == LAST_BYTE) begin
                     byte_d  = '0;
                     cnt_d   = 2'd0;
                     state_d = COLLECT;
                  end else begin
                     byte_d = byte_q + 1'b1;
                  end
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   // State and registered outputs; Reset clears everything immediately.
   always_ff @(posedge PixelClk or posedge Reset) begin
      if (Reset) begin
         state_q <= COLLECT;
         cnt_q   <= 2'd0;
         byte_q  <= '0;
         addr_q  <= '0;
         for (int i = 0; i < PSIZE; i++) pix_q[i] <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= 8'h00;
         idx_q   <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
         req_q   <= req_d;
         done_q  <= done_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         waddr_q <= waddr_d;
      end
   end

   assign bus.PixelReady = pixel_ready;
   assign bus.ReqWrite   = req_q;
   assign bus.DataOut    = data_q;
   assign bus.WriteIndex = idx_q;
   assign bus.WriteAddr  = waddr_q;
   assign bus.FrameDone  = done_q;
endmodule

// File: tb/tb_vpacker.sv
// Self-checking bench for vpacker: directed scenarios plus random traffic.
// A reference model tracks accepted pixels and unpacks every emitted group
// of three bytes back into four pixels.
module tb_vpacker;
   localparam int FB = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vpacker_if #(.BPP(6), .IWIDTH(2), .AWIDTH(16)) bus ();

   vpacker #(
      .BPP(6), .PSIZE(4), .IWIDTH(2), .AWIDTH(16), .FRAME_BYTES(FB)
   ) dut (
      .PixelClk (clk),
      .Reset    (rst),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         idx;
      int         addr;
      logic       done;
      int         cyc;
   } strobe_t;

   strobe_t    slog[$];
   logic [5:0] partial[$];
   logic [5:0] full[$];
   logic [23:0] word;
   int grp_n, maddr, acc_total, cyc, checks, errors, rlow, last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      partial.delete();
      full.delete();
      grp_n = 0;
      maddr = 0;
      word  = '0;
   endtask

   // Called once per falling edge: checks the strobe from the last rising edge,
   // then records what the next rising edge will accept.
   task automatic mon();
      strobe_t    s;
      logic [5:0] e;
      if (rst) begin
         clear_model();
         return;
      end
      if (bus.ReqWrite) begin
         s.data = bus.DataOut;
         s.idx  = int'(bus.WriteIndex);
         s.addr = int'(bus.WriteAddr);
         s.done = bus.FrameDone;
         s.cyc  = cyc;
         slog.push_back(s);
         check("m_index", 32'(bus.WriteIndex), 32'(grp_n));
         check("m_addr",  32'(bus.WriteAddr),  32'(maddr));
         check("m_done",  32'(bus.FrameDone),  32'(maddr == FB - 1));
         maddr = (maddr + 1) % FB;
         word[8*grp_n +: 8] = bus.DataOut;
         grp_n++;
         if (grp_n == 3) begin
            grp_n = 0;
            if (full.size() < 4) begin
               check("m_orphan", 32'(full.size()), 32'd4);
            end else begin
               for (int k = 0; k < 4; k++) begin
                  e = full.pop_front();
                  check("m_pixel", 32'(word[6*k +: 6]), 32'(e));
               end
            end
         end
      end else begin
         check("m_done_idle", 32'(bus.FrameDone), 32'd0);
      end
      check("m_ready", 32'(bus.PixelReady), 32'(full.size() == 0 && !bus.FrameStart));
      if (!bus.PixelReady) rlow++;
      if (bus.FrameStart) begin
         clear_model();
      end else if (bus.PixelValid && bus.PixelReady) begin
         partial.push_back(bus.PixelIn);
         acc_total++;
         if (partial.size() == 4) begin
            while (partial.size() > 0) full.push_back(partial.pop_front());
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_px(input logic [5:0] p);
      bit got;
      got = 1'b0;
      bus.PixelIn    = p;
      bus.PixelValid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.PixelReady;
         mon();
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.PixelValid = 1'b0;
      last_acc = cyc;
      check("send_accept", 32'(got), 32'd1);
   endtask

   task automatic send_ref_group();
      send_px(6'h15);
      send_px(6'h2A);
      send_px(6'h3F);
      send_px(6'h01);
   endtask

   task automatic frame_start();
      bus.FrameStart = 1'b1;
      step();
      bus.FrameStart = 1'b0;
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_ready"}, 32'(bus.PixelReady), 32'd0);
      check({tag, "_req"},   32'(bus.ReqWrite),   32'd0);
      check({tag, "_data"},  32'(bus.DataOut),    32'd0);
      check({tag, "_index"}, 32'(bus.WriteIndex), 32'd0);
      check({tag, "_addr"},  32'(bus.WriteAddr),  32'd0);
      check({tag, "_done"},  32'(bus.FrameDone),  32'd0);
   endtask

   logic [7:0] ref_bytes [3];
   int         exp_cyc [3];
   int         base, r0, a0, n;

   initial begin
      ref_bytes = '{8'h95, 8'hFA, 8'h07};
      bus.PixelIn    = '0;
      bus.PixelValid = 1'b0;
      bus.FrameStart = 1'b0;
      bus.MemReady   = 1'b1;
      checks = 0; errors = 0; cyc = 0; rlow = 0; acc_total = 0; last_acc = 0;
      clear_model();

      // Reset state
      idle(2);
      @(negedge clk);
      check_outputs_reset("reset");
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      step();

      // Reference group, memory always ready: back-to-back strobes
      base = slog.size();
      r0   = rlow;
      send_ref_group();
      n = last_acc;
      idle(6);
      check("t1_count", 32'(slog.size() - base), 32'd3);
      if (slog.size() >= base + 3) begin
         for (int k = 0; k < 3; k++) begin
            check("t1_data",  32'(slog[base+k].data), 32'(ref_bytes[k]));
            check("t1_index", 32'(slog[base+k].idx),  32'(k));
            check("t1_addr",  32'(slog[base+k].addr), 32'(k));
            check("t1_cycle", 32'(slog[base+k].cyc),  32'(n + k + 1));
         end
      end
      check("t1_ready_low", 32'(rlow - r0), 32'd3);

      // Same group with MemReady stalls
      frame_start();
      base = slog.size();
      send_ref_group();
      n = last_acc;
      exp_cyc = '{n + 1, n + 4, n + 6};
      for (int i = 0; i < 6; i++) begin
         bus.MemReady = (i == 0 || i == 3 || i == 5);
         step();
      end
      bus.MemReady = 1'b1;
      idle(4);
      check("t2_count", 32'(slog.size() - base), 32'd3);
      if (slog.size() >= base + 3) begin
         for (int k = 0; k < 3; k++) begin
            check("t2_data",  32'(slog[base+k].data), 32'(ref_bytes[k]));
            check("t2_index", 32'(slog[base+k].idx),  32'(k));
            check("t2_addr",  32'(slog[base+k].addr), 32'(k));
            check("t2_cycle", 32'(slog[base+k].cyc),  32'(exp_cyc[k]));
         end
      end

      // Frame wrap: three groups at a 6-byte frame
      frame_start();
      base = slog.size();
      for (int i = 0; i < 12; i++) send_px(6'($urandom));
      idle(6);
      check("t3_count", 32'(slog.size() - base), 32'd9);
      if (slog.size() >= base + 9) begin
         for (int k = 0; k < 9; k++) begin
            check("t3_addr", 32'(slog[base+k].addr), 32'(k % FB));
            check("t3_done", 32'(slog[base+k].done), 32'(k == FB - 1));
         end
      end

      // FrameStart discards a partial group
      frame_start();
      send_px(6'h2A);
      send_px(6'h3F);
      bus.FrameStart = 1'b1;
      bus.PixelValid = 1'b1;
      bus.PixelIn    = 6'h3F;
      @(negedge clk);
      check("t4_fs_ready", 32'(bus.PixelReady), 32'd0);
      mon();
      @(posedge clk);
      #1;
      cyc++;
      bus.FrameStart = 1'b0;
      bus.PixelValid = 1'b0;
      base = slog.size();
      send_ref_group();
      idle(6);
      check("t4_count", 32'(slog.size() - base), 32'd3);
      if (slog.size() > base) begin
         check("t4_data", 32'(slog[base].data), 32'h95);
         check("t4_addr", 32'(slog[base].addr), 32'd0);
      end

      // Reset between the B0 and B1 strobes
      frame_start();
      step();
      send_ref_group();
      step();
      @(negedge clk);
      check("t5_b0_req",  32'(bus.ReqWrite), 32'd1);
      check("t5_b0_data", 32'(bus.DataOut),  32'h95);
      mon();
      #1;
      rst = 1'b1;
      #1;
      check_outputs_reset("t5_async");
      @(posedge clk);
      #1;
      cyc++;
      step();
      rst = 1'b0;
      base = slog.size();
      send_ref_group();
      idle(6);
      check("t5_count", 32'(slog.size() - base), 32'd3);
      if (slog.size() > base) begin
         check("t5_data",  32'(slog[base].data), 32'h95);
         check("t5_index", 32'(slog[base].idx),  32'd0);
         check("t5_addr",  32'(slog[base].addr), 32'd0);
      end

      // Random traffic through the model unpacker
      frame_start();
      a0   = acc_total;
      base = slog.size();
      for (int i = 0; i < 1500; i++) begin
         bus.PixelValid = ($urandom_range(9) < 7);
         bus.PixelIn    = 6'($urandom);
         bus.MemReady   = ($urandom_range(9) < 6);
         step();
      end
      bus.PixelValid = 1'b0;
      bus.MemReady   = 1'b1;
      idle(8);
      check("rand_bytes",   32'(slog.size() - base), 32'(3 * ((acc_total - a0) / 4)));
      check("rand_pending", 32'(full.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
